// File: rtl/video_palframe_dither.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : video_palframe_dither
// Description : Palette-plus-frame video output stage. Selects the pixel or
//               border palette index, looks it up in an RGB palette RAM and
//               quantises each channel to DAC width with frame-shifted ordered
//               (Bayer) dithering. Also provides CPU palette write/readback.
// Revision    : 1.0 - initial release
// ============================================================================
module video_palframe_dither #(
  parameter int IN_W   = 4,  // palette bits per channel
  parameter int OUT_W  = 2,  // DAC bits per channel
  parameter int PAL_AW = 8,  // palette address width
  parameter int MATRIX = 2,  // Bayer matrix size, 2 or 4
  parameter int XDIV   = 2   // clocks per dither column, power of two
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hpix,
  input  logic                vpix,
  input  logic                hblank,
  input  logic                vblank,
  input  logic                hsync_start,
  input  logic                vsync,
  input  logic [PAL_AW-1:0]   pixels,
  input  logic [PAL_AW-1:0]   border,
  input  logic                border_sync,
  input  logic                border_sync_ena,
  input  logic                dith_ena,
  input  logic                pal_we,
  input  logic [PAL_AW-1:0]   pal_waddr,
  input  logic [3*IN_W-1:0]   pal_wdata,
  input  logic [PAL_AW-1:0]   pal_raddr,
  output logic [3*IN_W-1:0]   pal_rdata,
  output logic [3*OUT_W-1:0]  color
);

  localparam int c_YW    = $clog2(MATRIX);    // matrix row/column index width
  localparam int c_SH    = $clog2(XDIV);      // column divider shift
  localparam int c_XW    = c_YW + c_SH;       // x counter width
  localparam int c_PW    = 2 * c_YW;          // frame phase width
  localparam int c_SW    = IN_W + OUT_W;      // scaled channel width
  localparam int c_TW    = IN_W + 4;          // threshold working width
  localparam int c_DEPTH = 1 << PAL_AW;
  localparam logic [c_SW-1:0] c_L = c_SW'((1 << OUT_W) - 1);

  // Palette storage: no reset, contents undefined until written
  logic [3*IN_W-1:0] r_pal [c_DEPTH];

  logic [PAL_AW-1:0] r_synced_border;
  logic [PAL_AW-1:0] r_idx;
  logic              r_hblank_d1, r_vblank_d1;
  logic              r_hblank_d2, r_vblank_d2;
  logic [3*IN_W-1:0] r_rgb;

  logic [c_XW-1:0]   r_xcnt;
  logic [c_YW-1:0]   r_ycnt;
  logic [c_PW-1:0]   r_phase;
  logic              r_vsync;
  logic              w_vsync_start;

  logic [c_YW-1:0]   w_dx, w_ix, w_iy;
  logic [3:0]        w_bayer;
  logic [c_TW-1:0]   w_thr;
  logic [OUT_W-1:0]  w_q_r, w_q_g, w_q_b;

  // Quantise one channel: base level plus a one-step bump decided either by
  // the dither threshold or by the half-step bit (round to nearest).
  function automatic logic [OUT_W-1:0] quant(
    input logic [IN_W-1:0] v,
    input logic [c_TW-1:0] thr,
    input logic            dith
  );
    logic [c_SW-1:0]  s;
    logic [OUT_W-1:0] base;
    logic [IN_W-1:0]  frac;
    logic             up;
    s    = c_SW'(v) * c_L;
    base = s[c_SW-1:IN_W];
    frac = s[IN_W-1:0];
    up   = dith ? (c_TW'(frac) > thr) : frac[IN_W-1];
    return base + OUT_W'(up);
  endfunction

  // Palette write port; reads elsewhere see the old word in the write cycle
  always_ff @(posedge clk) begin
    if (pal_we) r_pal[pal_waddr] <= pal_wdata;
  end

  // CPU readback, independent of the video read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pal_rdata <= '0;
    else     pal_rdata <= r_pal[pal_raddr];
  end

  // Border index latch used when the border must change only on sync strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_synced_border <= '0;
    else if (border_sync) r_synced_border <= border;
  end

  assign w_vsync_start = vsync & ~r_vsync;

  // Dither position counters: column, row and per-frame matrix phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_xcnt  <= '0;
      r_ycnt  <= '0;
      r_phase <= '0;
      r_vsync <= 1'b0;
    end else begin
      r_xcnt  <= r_xcnt + c_XW'(1);
      r_vsync <= vsync;
      if (w_vsync_start) begin
        r_ycnt  <= '0;
        r_phase <= r_phase + c_PW'(1);
      end else if (hsync_start) begin
        r_ycnt  <= r_ycnt + c_YW'(1);
      end
    end
  end

  // S0: pick pixel or border index, register blanking alongside
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx       <= '0;
      r_hblank_d1 <= 1'b0;
      r_vblank_d1 <= 1'b0;
    end else begin
      r_idx       <= (hpix & vpix) ? pixels
                                   : (border_sync_ena ? r_synced_border : border);
      r_hblank_d1 <= hblank;
      r_vblank_d1 <= vblank;
    end
  end

  // S1: synchronous palette read, blanking delayed to match
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rgb       <= '0;
      r_hblank_d2 <= 1'b0;
      r_vblank_d2 <= 1'b0;
    end else begin
      r_rgb       <= r_pal[r_idx];
      r_hblank_d2 <= r_hblank_d1;
      r_vblank_d2 <= r_vblank_d1;
    end
  end

  // Matrix coordinates: frame phase rotates the pattern in x and y
  assign w_dx = c_YW'(r_xcnt >> c_SH);
  assign w_ix = w_dx + r_phase[c_YW-1:0];
  assign w_iy = r_ycnt + r_phase[c_PW-1:c_YW];

  if (MATRIX == 4) begin : g_bayer4
    // 4x4 ordered-dither matrix lookup
    always_comb begin
      w_bayer = 4'd0;
      case ({w_iy, w_ix})
        4'd0:  w_bayer = 4'd0;
        4'd1:  w_bayer = 4'd8;
        4'd2:  w_bayer = 4'd2;
        4'd3:  w_bayer = 4'd10;
        4'd4:  w_bayer = 4'd12;
        4'd5:  w_bayer = 4'd4;
        4'd6:  w_bayer = 4'd14;
        4'd7:  w_bayer = 4'd6;
        4'd8:  w_bayer = 4'd3;
        4'd9:  w_bayer = 4'd11;
        4'd10: w_bayer = 4'd1;
        4'd11: w_bayer = 4'd9;
        4'd12: w_bayer = 4'd15;
        4'd13: w_bayer = 4'd7;
        4'd14: w_bayer = 4'd13;
        4'd15: w_bayer = 4'd5;
        default: w_bayer = 4'd0;
      endcase
    end
  end else begin : g_bayer2
    // 2x2 ordered-dither matrix lookup
    always_comb begin
      w_bayer = 4'd0;
      case ({w_iy, w_ix})
        2'd0: w_bayer = 4'd0;
        2'd1: w_bayer = 4'd2;
        2'd2: w_bayer = 4'd3;
        2'd3: w_bayer = 4'd1;
        default: w_bayer = 4'd0;
      endcase
    end
  end

  // Threshold scaled to the channel fraction range (power-of-two, exact)
  assign w_thr = (c_TW'(w_bayer) << IN_W) >> c_PW;

  assign w_q_r = quant(r_rgb[3*IN_W-1:2*IN_W], w_thr, dith_ena);
  assign w_q_g = quant(r_rgb[2*IN_W-1:IN_W],   w_thr, dith_ena);
  assign w_q_b = quant(r_rgb[IN_W-1:0],        w_thr, dith_ena);

  // S2: quantised colour in DAC order {G,R,B}, black during blanking
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             color <= '0;
    else if (r_hblank_d2 | r_vblank_d2)  color <= '0;
    else                                 color <= {w_q_g, w_q_r, w_q_b};
  end

endmodule
`default_nettype wire

// File: tb/tb_video_palframe_dither.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_video_palframe_dither
// Description : Self-checking bench for video_palframe_dither (2x2 instance
//               with a cycle model, plus a 4x4 instance for coverage counts).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_palframe_dither;

  localparam int IN_W  = 4;
  localparam int OUT_W = 2;
  localparam int AW    = 8;
  localparam int M     = 2;
  localparam int XD    = 2;

  logic clk = 1'b0;
  logic rst;
  logic hpix, vpix, hblank, vblank, hsync_start, vsync;
  logic [AW-1:0] pixels, border, pal_waddr, pal_raddr;
  logic border_sync, border_sync_ena, dith_ena, pal_we;
  logic [3*IN_W-1:0] pal_wdata, pal_rdata, pal_rdata_b;
  logic [3*OUT_W-1:0] color, color_b;

  always #5 clk = ~clk;

  video_palframe_dither #(.IN_W(IN_W), .OUT_W(OUT_W), .PAL_AW(AW), .MATRIX(M), .XDIV(XD)) dut (
    .clk(clk), .rst(rst), .hpix(hpix), .vpix(vpix), .hblank(hblank), .vblank(vblank),
    .hsync_start(hsync_start), .vsync(vsync), .pixels(pixels), .border(border),
    .border_sync(border_sync), .border_sync_ena(border_sync_ena), .dith_ena(dith_ena),
    .pal_we(pal_we), .pal_waddr(pal_waddr), .pal_wdata(pal_wdata), .pal_raddr(pal_raddr),
    .pal_rdata(pal_rdata), .color(color));

  video_palframe_dither #(.IN_W(IN_W), .OUT_W(OUT_W), .PAL_AW(AW), .MATRIX(4), .XDIV(1)) dut4 (
    .clk(clk), .rst(rst), .hpix(hpix), .vpix(vpix), .hblank(hblank), .vblank(vblank),
    .hsync_start(hsync_start), .vsync(vsync), .pixels(pixels), .border(border),
    .border_sync(border_sync), .border_sync_ena(border_sync_ena), .dith_ena(dith_ena),
    .pal_we(pal_we), .pal_waddr(pal_waddr), .pal_wdata(pal_wdata), .pal_raddr(pal_raddr),
    .pal_rdata(pal_rdata_b), .color(color_b));

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_pal [256];
  bit m_known [256];
  int m_edges, m_line, m_frames, m_sb;
  bit m_vs_prev;
  int p0_idx, p1_rgb;
  bit p0_blank, p1_blank, p1_known;
  int e_color, e_rdata;
  bit e_color_known, e_rdata_known;

  // Bayer matrix built recursively from the 2x2 pattern
  function automatic int bayer(int m, int y, int x);
    int b_lo, b_hi;
    b_lo = 2 * ((x % 2) ^ (y % 2)) + (y % 2);
    if (m == 2) return b_lo;
    b_hi = 2 * (((x / 2) % 2) ^ ((y / 2) % 2)) + ((y / 2) % 2);
    return 4 * b_lo + b_hi;
  endfunction

  function automatic int quant(int v, int thr, bit dith);
    int s, base, frac;
    s    = v * ((1 << OUT_W) - 1);
    base = s / (1 << IN_W);
    frac = s % (1 << IN_W);
    if (dith) return base + ((frac > thr) ? 1 : 0);
    return base + ((frac >= (1 << (IN_W - 1))) ? 1 : 0);
  endfunction

  function automatic int pack(int rgb, int thr, bit dith);
    int mask, r, g, b;
    mask = (1 << IN_W) - 1;
    r = (rgb >> (2 * IN_W)) & mask;
    g = (rgb >> IN_W) & mask;
    b = rgb & mask;
    return (quant(g, thr, dith) << (2 * OUT_W)) | (quant(r, thr, dith) << OUT_W) | quant(b, thr, dith);
  endfunction

  task automatic model_reset();
    m_edges = 0; m_line = 0; m_frames = 0; m_sb = 0; m_vs_prev = 0;
    p0_idx = 0; p0_blank = 0;
    p1_rgb = 0; p1_blank = 0; p1_known = 1;
    e_color = 0; e_color_known = 1;
    e_rdata = 0; e_rdata_known = 1;
  endtask

  // Predict the outputs after the coming clock edge from the current inputs
  task automatic model_step();
    int ph, ix, iy, thr;
    ph  = m_frames % (M * M);
    ix  = ((m_edges % (M * XD)) / XD + ph % M) % M;
    iy  = (m_line + ph / M) % M;
    thr = bayer(M, iy, ix) * (1 << IN_W) / (M * M);
    if (p1_blank) begin
      e_color = 0; e_color_known = 1;
    end else begin
      e_color = pack(p1_rgb, thr, dith_ena); e_color_known = p1_known;
    end
    p1_rgb   = m_pal[p0_idx];
    p1_known = m_known[p0_idx];
    p1_blank = p0_blank;
    p0_idx   = (hpix && vpix) ? int'(pixels) : (border_sync_ena ? m_sb : int'(border));
    p0_blank = hblank | vblank;
    e_rdata       = m_pal[pal_raddr];
    e_rdata_known = m_known[pal_raddr];
    if (pal_we) begin
      m_pal[pal_waddr]   = pal_wdata;
      m_known[pal_waddr] = 1'b1;
    end
    if (border_sync) m_sb = border;
    m_edges++;
    if (vsync && !m_vs_prev) begin
      m_line = 0;
      m_frames++;
    end else if (hsync_start) begin
      m_line++;
    end
    m_vs_prev = vsync;
  endtask

  // Compare process: every falling edge, check then advance the model
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        model_reset();
        check("rst_color", color, 0);
        check("rst_rdata", pal_rdata, 0);
      end else begin
        if (e_color_known) check("color", color, e_color);
        if (e_rdata_known) check("pal_rdata", pal_rdata, e_rdata);
        model_step();
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic step_n(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input int a, input int d);
    pal_we = 1'b1; pal_waddr = AW'(a); pal_wdata = (3*IN_W)'(d);
    step();
    pal_we = 1'b0;
  endtask

  // Count R==1 (2x2 DUT) and R==1 (4x4 DUT) over ncyc outputs, line length 4
  task automatic coverage(input int idx, input int ncyc, output int cnt_a, output int cnt_b);
    pixels = AW'(idx); hpix = 1'b1; vpix = 1'b1; dith_ena = 1'b1;
    step_n(3);
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < ncyc + 4; i++) begin
      hsync_start = (i % 4 == 0);
      @(negedge clk);
      if (i >= 4) begin
        if (color[2*OUT_W-1:OUT_W] == 2'd1)   cnt_a++;
        if (color_b[2*OUT_W-1:OUT_W] == 2'd1) cnt_b++;
      end
      step();
    end
    hsync_start = 1'b0;
  endtask

  int ca, cb;

  initial begin
    rst = 1'b1;
    hpix = 0; vpix = 0; hblank = 0; vblank = 0; hsync_start = 0; vsync = 0;
    pixels = '0; border = '0; border_sync = 0; border_sync_ena = 0; dith_ena = 0;
    pal_we = 0; pal_waddr = '0; pal_wdata = '0; pal_raddr = '0;
    #23;
    check("reset_color", color, 0);
    check("reset_rdata", pal_rdata, 0);
    step();
    rst = 1'b0;

    // Palette setup
    wr(0, 'h000); wr(1, 'h400); wr(2, 'h800); wr(3, 'hFFF);
    wr(5, 'h123); wr(6, 'h100); wr(7, 'h5A3); wr(8, 'h7C9);

    // Same-cycle write/read returns old data, new data one clock later
    pal_raddr = 8'h05; pal_we = 1'b1; pal_waddr = 8'h05; pal_wdata = 12'hF80;
    step();
    pal_we = 1'b0;
    check("rd_same_cycle", pal_rdata, 'h123);
    step();
    check("rd_after_write", pal_rdata, 'hF80);

    // Pixel path, round to nearest
    hpix = 1; vpix = 1; pixels = 8'h05; dith_ena = 0;
    step_n(3);
    check("pix_F80", color, 'h2C);

    // Border path
    vpix = 0; border = 8'h07;
    step_n(3);
    check("border_5A3", color, 'h25);

    // Synced border: only changes on strobe
    border_sync_ena = 1;
    step_n(3);
    check("synced_init", color, 0);
    border = 8'h08; border_sync = 1;
    step();
    border_sync = 0; border = 8'h07;
    step_n(3);
    check("synced_7C9", color, 'h26);
    step_n(3);
    check("synced_hold", color, 'h26);
    border_sync_ena = 0;

    // Blanking and extremes
    vpix = 1; pixels = 8'h03; hblank = 1;
    step_n(3);
    check("hblank", color, 0);
    hblank = 0; vblank = 1;
    step_n(3);
    check("vblank", color, 0);
    vblank = 0;
    step_n(3);
    check("v15_round", color, 'h3F);
    dith_ena = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i >= 2) check("v15_dith", color, 'h3F);
    end
    pixels = 8'h00;
    step_n(3);
    check("v0_dith", color, 0);

    // Ordered-dither coverage over full matrix periods
    coverage(1, 16, ca, cb);
    check("cov_v4_2x2", ca, 12);
    check("cov_v4_4x4", cb, 12);
    coverage(2, 16, ca, cb);
    check("cov_v8_2x2", ca, 8);
    check("cov_v8_4x4", cb, 8);
    coverage(6, 16, ca, cb);
    check("cov_v1_2x2", ca, 4);
    check("cov_v1_4x4", cb, 3);

    // Several frames, vsync rise coinciding with hsync_start, some blanking
    pixels = 8'h01;
    for (int f = 0; f < 5; f++) begin
      for (int c = 0; c < 24; c++) begin
        vsync       = (c < 2);
        hsync_start = (c % 4 == 0);
        hblank      = (c % 8 == 7);
        dith_ena    = (f != 3);
        step();
      end
    end
    vsync = 0; hsync_start = 0; hblank = 0; dith_ena = 0;

    // Mid-line asynchronous reset
    pixels = 8'h05;
    step_n(4);
    check("pre_rst_color", color, 'h2C);
    #1 rst = 1'b1;
    #1;
    check("async_rst_color", color, 0);
    check("async_rst_rdata", pal_rdata, 0);
    step_n(2);
    rst = 1'b0;
    step();
    check("post_rst_1", color, 0);
    step();
    check("post_rst_2", color, 0);
    step();
    check("post_rst_3", color, 'h2C);
    step_n(4);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
